cpu_controller: RTL



---
 rtl/cpu_controller.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_controller.sv
// ---------------------------------------------------------------------------
// cpu_controller
//
// Multi-cycle control unit placed directly upstream of the datapath. It
// fetches 16-bit instructions into an instruction register (IR), decodes
// them and sequences the datapath control lines. It owns the program counter
// and the memory request handshake used for fetch, LDR and STR.
//
// Instruction fields: IR[15:13] opcode, IR[12:11] op, IR[10:8] Rn,
//                     IR[7:5] Rd, IR[4:3] sh, IR[2:0] Rm.
//
// Optional feature macro: CPU_BRANCH_EN
//   When it is defined, opcode 001 op 00 is a conditional PC-relative branch
//   with cond = IR[10:8]. When it is undefined, opcode 001 is an illegal
//   encoding.
//
// Parameters:
//   RESET_PC      PC value loaded on reset
//   ILLEGAL_HALT  1: an undefined encoding halts; 0: it behaves as a NOP
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   mem_rdata     memory read data (the datapath takes it as mdata directly)
//   mem_ready     memory completes the current request on this edge
//   datapath_out  ALU result from the datapath
//   Z_out         status flags {V,N,Z}
//   mem_req       memory access request
//   mem_we        1 = write, 0 = read
//   mem_addr      access address
//   mem_wdata     store data (datapath_out while storing)
//   loads, asel, bsel, write, vsel, ALUop, shift  datapath controls
//   readA, readB, writenum                        register selects
//   PC            program counter
//   sximm5        sign-extended IR[4:0]
//   sximm8        sign-extended IR[7:0]
//   halted        high while halted
// ---------------------------------------------------------------------------
module cpu_controller #(
  parameter logic [7:0] RESET_PC     = 8'h00,
  parameter int         ILLEGAL_HALT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic [15:0] datapath_out,
  input  logic [2:0]  Z_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        write,
  output logic [1:0]  vsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [2:0]  readA,
  output logic [2:0]  readB,
  output logic [2:0]  writenum,
  output logic [7:0]  PC,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_ADDR,
    S_LOAD,
    S_STORE,
    S_HALT
  } state_t;

  // Where the decoder sends an encoding it does not recognise.
  localparam state_t ILLEGAL_NEXT = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;

  state_t      state_q;
  state_t      decode_next_d;
  logic [7:0]  pc_q;
  logic [7:0]  data_addr_q;
  logic [15:0] ir_q;

  // Instruction fields
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  // -------------------------------------------------------------------------
  // Optional conditional branch
  // -------------------------------------------------------------------------
`ifdef CPU_BRANCH_EN
  logic       is_branch_d;
  logic       branch_taken_d;
  logic [7:0] pc_branch_d;
  logic       flag_z;
  logic       flag_n;
  logic       flag_v;

  assign flag_z      = Z_out[0];
  assign flag_n      = Z_out[1];
  assign flag_v      = Z_out[2];
  assign is_branch_d = (opcode == 3'b001) && (op == 2'b00);
  // PC already points past the branch; the offset wraps within 8 bits.
  assign pc_branch_d = pc_q + ir_q[7:0];

  always_comb begin
    branch_taken_d = 1'b0;
    case (rn)
      3'b000:  branch_taken_d = 1'b1;
      3'b001:  branch_taken_d = flag_z;
      3'b010:  branch_taken_d = !flag_z;
      3'b011:  branch_taken_d = (flag_n != flag_v);
      3'b100:  branch_taken_d = (flag_n != flag_v) || flag_z;
      default: branch_taken_d = 1'b0;
    endcase
  end
`else
  // Status flags only matter to the branch; fold them so they are not dangling.
  logic unused_status;
  assign unused_status = ^Z_out;
`endif

  // -------------------------------------------------------------------------
  // Decode: choose the state that follows S_DECODE
  // -------------------------------------------------------------------------
  always_comb begin
    decode_next_d = ILLEGAL_NEXT;
    case (opcode)
      3'b110, 3'b101: decode_next_d = S_EXEC;
      3'b011, 3'b100: begin
        if (op == 2'b00) begin
          decode_next_d = S_ADDR;
        end
      end
      3'b111: decode_next_d = S_HALT;
`ifdef CPU_BRANCH_EN
      3'b001: begin
        if (op == 2'b00) begin
          decode_next_d = S_EXEC;
        end
      end
`endif
      default: decode_next_d = ILLEGAL_NEXT;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, PC, IR and data address
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RESET;
      pc_q        <= RESET_PC;
      ir_q        <= 16'h0000;
      data_addr_q <= 8'h00;
    end else begin
      case (state_q)
        S_RESET: state_q <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata;
            pc_q    <= pc_q + 8'd1;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: state_q <= decode_next_d;
        S_EXEC: begin
`ifdef CPU_BRANCH_EN
          if (is_branch_d && branch_taken_d) begin
            pc_q <= pc_branch_d;
          end
`endif
          state_q <= S_FETCH;
        end
        S_ADDR: begin
          // Only the low byte of the effective address reaches memory.
          data_addr_q <= datapath_out[7:0];
          state_q     <= (opcode == 3'b011) ? S_LOAD : S_STORE;
        end
        S_LOAD, S_STORE: begin
          if (mem_ready) begin
            state_q <= S_FETCH;
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_RESET;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Control outputs: decoded from the registered state and IR only, so they
  // are glitch-free relative to the inputs (except write during a load,
  // which must follow mem_ready on the completing edge). Because state
  // resets asynchronously, mem_req drops the instant reset rises.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 16'h0000;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    write     = 1'b0;
    vsel      = 2'b00;
    ALUop     = 2'b00;
    shift     = 2'b00;
    readA     = 3'b000;
    readB     = 3'b000;
    writenum  = 3'b000;
    halted    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      S_EXEC: begin
        case ({opcode, op})
          5'b110_10: begin            // MOV Rn,#im8
            vsel     = 2'b10;
            writenum = rn;
            write    = 1'b1;
          end
          5'b110_00: begin            // MOV Rd,Rm,sh (A operand forced to 0)
            asel     = 1'b1;
            readB    = rm;
            shift    = sh;
            writenum = rd;
            write    = 1'b1;
          end
          5'b101_00, 5'b101_10, 5'b101_11: begin  // ADD / AND / MVN
            readA    = rn;
            readB    = rm;
            shift    = sh;
            ALUop    = op;
            writenum = rd;
            write    = 1'b1;
          end
          5'b101_01: begin            // CMP: only the status register loads
            readA = rn;
            readB = rm;
            shift = sh;
            ALUop = 2'b01;
            loads = 1'b1;
          end
          default: ;                  // branch and unused ops drive nothing
        endcase
      end
      S_ADDR: begin                   // Rn + sximm5
        readA = rn;
        bsel  = 1'b1;
      end
      S_LOAD: begin
        mem_req  = 1'b1;
        mem_addr = data_addr_q;
        vsel     = 2'b11;
        writenum = rd;
        write    = mem_ready;
      end
      S_STORE: begin                  // Rd passed through with A forced to 0
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = data_addr_q;
        readB     = rd;
        asel      = 1'b1;
        mem_wdata = datapath_out;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign PC     = pc_q;
  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

endmodule
